// File: rtl/ibus_timer.sv
// ibus_timer: prescaled 16-bit compare timer on the CPU ibus.
//
// Ports:
//   clk, rst      - system clock; synchronous active-high reset
//   ibus_ren      - read strobe, one cycle per access
//   ibus_radr     - read word address [19:2]
//   ibus32_rdata  - registered read data, zero when not responding (OR-able)
//   ibus_wen      - write strobe, one cycle per access
//   ibus_wadr     - write word address [19:2]
//   ibus32_wdata  - write data
//   interrupt_0   - timer interrupt to cpu_top
//
// Register map (index = adr[4:2], selected when adr[19:5] == BASE_ADR):
//   0 CTRL [0]EN [1]AUTO [2]IE, 1 PRESCALE, 2 COMPARE, 3 COUNT,
//   4 STATUS [0]MATCH [1]MISS (write-1-to-clear), 5-7 reserved.
//
// Build option: define IBUS_TIMER_PULSE_EN to make interrupt_0 a one-cycle
// pulse per match instead of a level following MATCH & IE.
module ibus_timer #(
  parameter logic [14:0] BASE_ADR     = 15'h0000,
  parameter logic [15:0] PRESCALE_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ibus_ren,
  input  logic [19:2] ibus_radr,
  output logic [15:0] ibus32_rdata,
  input  logic        ibus_wen,
  input  logic [19:2] ibus_wadr,
  input  logic [15:0] ibus32_wdata,
  output logic        interrupt_0
);

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_PRESCALE = 3'd1,
    REG_COMPARE  = 3'd2,
    REG_COUNT    = 3'd3,
    REG_STATUS   = 3'd4
  } reg_idx_e;

  logic [2:0]  ctrl_q,     ctrl_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] compare_q,  compare_d;
  logic [15:0] count_q,    count_d;
  logic [15:0] pcnt_q,     pcnt_d;
  logic        match_q,    match_d;
  logic        miss_q,     miss_d;
  logic [15:0] rdata_q,    rdata_d;
  logic        irq_q,      irq_d;

  logic     rd_sel, wr_sel;
  reg_idx_e rd_idx, wr_idx;
  logic     tick, hit;

  always_comb begin
    rd_sel = ibus_ren && (ibus_radr[19:5] == BASE_ADR);
    wr_sel = ibus_wen && (ibus_wadr[19:5] == BASE_ADR);
    rd_idx = reg_idx_e'(ibus_radr[4:2]);
    wr_idx = reg_idx_e'(ibus_wadr[4:2]);

    tick = ctrl_q[0] && (pcnt_q == prescale_q);
    hit  = tick && (count_q == compare_q);

    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    count_d    = count_q;
    match_d    = match_q;
    miss_d     = miss_q;
    rdata_d    = '0;

    // pcnt only counts up; a PRESCALE below the current pcnt wraps via 16'hFFFF.
    if (!ctrl_q[0]) begin
      pcnt_d = '0;
    end else if (tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + 16'd1;
    end

    if (tick) begin
      if (hit) begin
        if (ctrl_q[1]) begin
          count_d = '0;
        end else begin
          ctrl_d[0] = 1'b0;
        end
      end else begin
        count_d = count_q + 16'd1;
      end
    end

    // Bus writes are applied after the timer update so they take priority.
    if (wr_sel) begin
      case (wr_idx)
        REG_CTRL:     ctrl_d     = ibus32_wdata[2:0];
        REG_PRESCALE: prescale_d = ibus32_wdata;
        REG_COMPARE:  compare_d  = ibus32_wdata;
        REG_COUNT:    count_d    = ibus32_wdata;
        default:      ;
      endcase
    end

    // Clear first, then set, so a match in the clearing cycle survives.
    if (wr_sel && (wr_idx == REG_STATUS)) begin
      match_d = match_q & ~ibus32_wdata[0];
      miss_d  = miss_q  & ~ibus32_wdata[1];
    end
    if (hit) begin
      match_d = 1'b1;
      if (match_q) begin
        miss_d = 1'b1;
      end
    end

    if (rd_sel) begin
      case (rd_idx)
        REG_CTRL:     rdata_d = {13'd0, ctrl_q};
        REG_PRESCALE: rdata_d = prescale_q;
        REG_COMPARE:  rdata_d = compare_q;
        REG_COUNT:    rdata_d = count_q;
        REG_STATUS:   rdata_d = {14'd0, miss_q, match_q};
        default:      rdata_d = '0;
      endcase
    end

`ifdef IBUS_TIMER_PULSE_EN
    irq_d = hit && ctrl_q[2];
`else
    irq_d = match_q && ctrl_q[2];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      prescale_q <= PRESCALE_RST;
      compare_q  <= '1;
      count_q    <= '0;
      pcnt_q     <= '0;
      match_q    <= 1'b0;
      miss_q     <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      count_q    <= count_d;
      pcnt_q     <= pcnt_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign ibus32_rdata = rdata_q;
  assign interrupt_0  = irq_q;

endmodule

// File: tb/tb_ibus_timer.sv
// Self-checking bench for ibus_timer (default level-interrupt build).
module tb_ibus_timer;

  localparam logic [14:0] BASE  = 15'h0123;
  localparam logic [14:0] OTHER = 15'h0124;
  localparam logic [15:0] PRST  = 16'h00A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_ren;
  logic [17:0] ibus_radr;
  logic [15:0] ibus32_rdata;
  logic        ibus_wen;
  logic [17:0] ibus_wadr;
  logic [15:0] ibus32_wdata;
  logic        interrupt_0;

  int unsigned nchecks = 0;
  int unsigned nerrors = 0;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] exp;
  } rdvec_t;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] wdata;
    logic [15:0] exp;
  } wrvec_t;

  rdvec_t rst_tab[5];
  wrvec_t wr_tab[7];

  ibus_timer #(
    .BASE_ADR     (BASE),
    .PRESCALE_RST (PRST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ibus_ren     (ibus_ren),
    .ibus_radr    (ibus_radr),
    .ibus32_rdata (ibus32_rdata),
    .ibus_wen     (ibus_wen),
    .ibus_wadr    (ibus_wadr),
    .ibus32_wdata (ibus32_wdata),
    .interrupt_0  (interrupt_0)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Write strobe is sampled at the next edge; returns 1ns after it.
  task automatic wr_a(input logic [14:0] base, input logic [2:0] idx, input logic [15:0] d);
    ibus_wen     = 1'b1;
    ibus_wadr    = {base, idx};
    ibus32_wdata = d;
    step();
    ibus_wen = 1'b0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] d);
    wr_a(BASE, idx, d);
  endtask

  // Read strobe sampled at the next edge; data is valid right after that edge.
  task automatic rd_a(input logic [14:0] base, input logic [2:0] idx, output logic [15:0] d);
    ibus_ren  = 1'b1;
    ibus_radr = {base, idx};
    step();
    d = ibus32_rdata;
    ibus_ren = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx, output logic [15:0] d);
    rd_a(BASE, idx, d);
  endtask

  task automatic check_reset_vals(input string tag);
    logic [15:0] d;
    for (int i = 0; i < 5; i++) begin
      rd(rst_tab[i].idx, d);
      chk($sformatf("%s rd idx%0d", tag, rst_tab[i].idx), d, rst_tab[i].exp);
      step();
      chk($sformatf("%s rdata idle after idx%0d", tag, rst_tab[i].idx), ibus32_rdata, 16'h0000);
    end
  endtask

  initial begin
    logic [15:0] d;

    rst_tab[0] = '{3'd0, 16'h0000};
    rst_tab[1] = '{3'd1, PRST};
    rst_tab[2] = '{3'd2, 16'hFFFF};
    rst_tab[3] = '{3'd3, 16'h0000};
    rst_tab[4] = '{3'd4, 16'h0000};

    wr_tab[0] = '{3'd0, 16'hFFFA, 16'h0002};
    wr_tab[1] = '{3'd1, 16'hABCD, 16'hABCD};
    wr_tab[2] = '{3'd2, 16'h8001, 16'h8001};
    wr_tab[3] = '{3'd3, 16'h7FFE, 16'h7FFE};
    wr_tab[4] = '{3'd4, 16'hFFFF, 16'h0000};
    wr_tab[5] = '{3'd5, 16'h1234, 16'h0000};
    wr_tab[6] = '{3'd7, 16'hFFFF, 16'h0000};

    rst          = 1'b1;
    ibus_ren     = 1'b0;
    ibus_wen     = 1'b0;
    ibus_radr    = '0;
    ibus_wadr    = '0;
    ibus32_wdata = '0;
    idle(3);
    chk("rdata in reset", ibus32_rdata, 16'h0000);
    chk("irq in reset", {15'd0, interrupt_0}, 16'h0000);
    rst = 1'b0;

    check_reset_vals("reset");

    // Register write/readback table (EN kept 0 so nothing counts).
    for (int i = 0; i < 7; i++) begin
      wr(wr_tab[i].idx, wr_tab[i].wdata);
      rd(wr_tab[i].idx, d);
      chk($sformatf("wr/rd idx%0d", wr_tab[i].idx), d, wr_tab[i].exp);
    end
    wr(3'd0, 16'h0000);

    // Periodic mode: PRESCALE=3, COMPARE=2 -> match every 12 clocks.
    wr(3'd1, 16'h0003);
    wr(3'd2, 16'h0002);
    wr(3'd3, 16'h0000);
    wr(3'd0, 16'h0007);           // EN edge E0
    idle(3);
    rd(3'd3, d);                  // sampled at E4 (tick edge): old value
    chk("auto count before first tick", d, 16'h0000);
    rd(3'd3, d);                  // sampled at E5
    chk("auto count after 4 clocks", d, 16'h0001);
    idle(7);                      // now E12+1: MATCH just set
    chk("auto irq not yet at E12", {15'd0, interrupt_0}, 16'h0000);
    rd(3'd4, d);                  // E13
    chk("auto status match", d, 16'h0001);
    chk("auto irq rises E13", {15'd0, interrupt_0}, 16'h0001);
    rd(3'd3, d);                  // E14
    chk("auto count reloaded", d, 16'h0000);
    wr(3'd4, 16'h0001);           // clear at E15
    chk("auto irq still high after clear edge", {15'd0, interrupt_0}, 16'h0001);
    step();                       // E16
    chk("auto irq falls", {15'd0, interrupt_0}, 16'h0000);
    idle(8);                      // E24+1
    chk("auto irq low at second match edge", {15'd0, interrupt_0}, 16'h0000);
    step();                       // E25
    chk("auto irq second period", {15'd0, interrupt_0}, 16'h0001);
    wr(3'd0, 16'h0000);
    wr(3'd4, 16'h0003);

    // One-shot mode.
    wr(3'd3, 16'h0000);
    wr(3'd0, 16'h0005);
    idle(20);
    rd(3'd0, d);
    chk("oneshot EN cleared", d, 16'h0004);
    rd(3'd3, d);
    chk("oneshot count held", d, 16'h0002);
    chk("oneshot irq", {15'd0, interrupt_0}, 16'h0001);
    wr(3'd4, 16'h0001);
    chk("oneshot irq at clear edge", {15'd0, interrupt_0}, 16'h0001);
    step();
    chk("oneshot irq falls", {15'd0, interrupt_0}, 16'h0000);

    // Sticky MATCH across two periods sets MISS.
    wr(3'd3, 16'h0000);
    wr(3'd0, 16'h0007);
    idle(30);
    rd(3'd4, d);
    chk("miss status", d, 16'h0003);
    wr(3'd0, 16'h0000);
    wr(3'd4, 16'h0002);
    rd(3'd4, d);
    chk("clear miss only", d, 16'h0001);
    wr(3'd4, 16'h0001);

    // COUNT write coincident with a tick: write wins, compare uses old COUNT.
    wr(3'd2, 16'h0005);
    wr(3'd3, 16'h0004);
    wr(3'd0, 16'h0003);           // E0, tick at E4
    idle(3);
    wr(3'd3, 16'h0005);           // sampled at E4
    rd(3'd4, d);
    chk("count write vs tick status", d, 16'h0000);
    rd(3'd3, d);
    chk("count write vs tick value", d, 16'h0005);
    wr(3'd0, 16'h0000);           // E7, before next tick

    // COUNT wrap 16'hFFFF -> 0 with PRESCALE=0 (tick every clock).
    wr(3'd1, 16'h0000);
    wr(3'd2, 16'h0001);
    wr(3'd3, 16'hFFFF);
    wr(3'd4, 16'h0003);
    wr(3'd0, 16'h0003);
    rd(3'd3, d);
    chk("wrap count E1", d, 16'hFFFF);
    rd(3'd3, d);
    chk("wrap count E2", d, 16'h0000);
    rd(3'd3, d);
    chk("wrap count E3", d, 16'h0001);
    rd(3'd3, d);
    chk("wrap count after match", d, 16'h0000);
    rd(3'd4, d);
    chk("wrap status", d, 16'h0001);
    wr(3'd0, 16'h0000);
    wr(3'd4, 16'h0003);

    // Decode: foreign base and reserved index.
    wr(3'd2, 16'h1234);
    wr_a(OTHER, 3'd2, 16'hBEEF);
    wr(3'd6, 16'hFFFF);
    rd_a(OTHER, 3'd2, d);
    chk("foreign base read", d, 16'h0000);
    rd(3'd6, d);
    chk("index 6 read", d, 16'h0000);
    rd(3'd2, d);
    chk("compare untouched", d, 16'h1234);

    // Read and write of the same register in one cycle: read sees old value.
    ibus_ren     = 1'b1;
    ibus_radr    = {BASE, 3'd2};
    ibus_wen     = 1'b1;
    ibus_wadr    = {BASE, 3'd2};
    ibus32_wdata = 16'h5555;
    step();
    ibus_ren = 1'b0;
    ibus_wen = 1'b0;
    chk("rd/wr same cycle old value", ibus32_rdata, 16'h1234);
    rd(3'd2, d);
    chk("rd/wr same cycle new value", d, 16'h5555);

    // Reset mid-count with interrupt active and a read in the reset cycle.
    wr(3'd1, 16'h0000);
    wr(3'd2, 16'h0001);
    wr(3'd3, 16'h0000);
    wr(3'd0, 16'h0007);
    idle(4);
    chk("irq before mid reset", {15'd0, interrupt_0}, 16'h0001);
    rst       = 1'b1;
    ibus_ren  = 1'b1;
    ibus_radr = {BASE, 3'd3};
    step();
    rst      = 1'b0;
    ibus_ren = 1'b0;
    chk("rdata after mid reset", ibus32_rdata, 16'h0000);
    chk("irq after mid reset", {15'd0, interrupt_0}, 16'h0000);
    check_reset_vals("midreset");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
